// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents: controller FSM state enum, x0 register index, EX-stage load-type
// encodings and a helper that decides whether a load-type field means "load".
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned LDT_W  = 3;
  localparam int unsigned WCNT_W = 8;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [REG_W-1:0] REG_X0 = REG_W'(0);

  // Load-type encodings carried by ex_readMem.
  localparam logic [LDT_W-1:0] LD_NONE  = 3'b000;
  localparam logic [LDT_W-1:0] LD_BYTE  = 3'b001;
  localparam logic [LDT_W-1:0] LD_HALF  = 3'b010;
  localparam logic [LDT_W-1:0] LD_WORD  = 3'b011;
  localparam logic [LDT_W-1:0] LD_BYTEU = 3'b100;
  localparam logic [LDT_W-1:0] LD_HALFU = 3'b101;

  // Any nonzero code is a load; reserved codes are treated as loads too so a
  // hazard is never missed.
  function automatic logic is_load(input logic [LDT_W-1:0] ld);
    case (ld)
      LD_BYTE, LD_HALF, LD_WORD, LD_BYTEU, LD_HALFU: is_load = 1'b1;
      default:                                       is_load = (ld != LD_NONE);
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears the count
//   inc  - advance by one this cycle (ignored once at all-ones)
//   q    - current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count up, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline.
// Drives hold/flush controls of the pipeline registers for memory-wait
// freezes, taken-branch/jump redirects and load-use bubbles, and keeps
// saturating stall and flush counters.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2    - ID-stage sources and whether they are read
//   ex_rd, ex_readMem, ex_writeReg - EX-stage destination, load type, writeback
//   ex_redirect                    - EX resolved a taken branch/jump
//   mem_req, mem_ready             - MEM-stage data access and its completion
//   pc_hold .. exmem_hold          - register keeps its contents (combinational)
//   ifid/idex/memwb_flush          - register loads a bubble (combinational)
//   mem_timeout                    - pulse on forced release of a memory wait
//   stall_cycles, flush_count      - saturating performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [LDT_W-1:0] ex_readMem,
  input  logic             ex_writeReg,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              w_at_limit;
  logic              w_mem_stall;
  logic              w_load_use;
  logic              w_flush_inc;

  // Wait budget exhausted: the pending access is released this cycle.
  assign w_at_limit  = (r_state == MEM_WAIT) && (r_wcnt == WCNT_W'(MEM_TIMEOUT));
  assign w_mem_stall = mem_req && !mem_ready && !w_at_limit;

  // x0 is never a real dependency; only sources the ID instruction reads count.
  assign w_load_use = is_load(ex_readMem) && ex_writeReg && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Next-state logic; in MEM_WAIT a stall is exactly the "keep waiting" case.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = MEM_WAIT;
          w_wcnt_nxt  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (w_mem_stall) begin
          w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        end else begin
          w_state_nxt = RUN;
          w_wcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Output logic: memory freeze over redirect over load-use.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_timeout = w_at_limit && mem_req && !mem_ready;
    if (w_mem_stall) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_hold   = 1'b1;
      exmem_hold  = 1'b1;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
    end
  end

  // A redirect is only honored when the pipeline is not frozen.
  assign w_flush_inc = ex_redirect && !w_mem_stall;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_hold),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_inc),
    .q   (flush_count)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32 core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their hold and flush inputs. It produces one-cycle bubbles for load-use hazards, flushes wrong-path instructions on a taken branch or jump resolved in EX, and freezes the pipeline while a data-memory access waits on `mem_ready`. It also keeps saturating stall and flush performance counters.

## Interface
- `MEM_TIMEOUT`, 16: maximum number of stall cycles per memory access before a forced release. Legal range 2..255.
- `CNT_W`, 32: width of the performance counters.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: the instruction in ID actually reads that source.
- `ex_rd` in 5: destination of the instruction in EX.
- `ex_readMem` in 3: load type in EX; nonzero means load.
- `ex_writeReg` in 1: EX instruction writes the register file.
- `ex_redirect` in 1: EX resolved a taken branch or jump; the PC mux selects the target.
- `mem_req` in 1: the MEM-stage instruction accesses data memory this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_hold`, `ifid_hold`, `idex_hold`, `exmem_hold` out 1 each: the register keeps its contents.
- `ifid_flush`, `idex_flush`, `memwb_flush` out 1 each: the register loads a bubble (all zero).
- `mem_timeout` out 1: one-cycle pulse when a forced release occurs.
- `stall_cycles` out `CNT_W`: count of cycles with `pc_hold`=1.
- `flush_count` out `CNT_W`: count of redirect flushes.

## Operation
- FSM states are `RUN` and `MEM_WAIT`. Wait counter `wcnt` is 8 bits.
- `mem_stall` = `mem_req` & !`mem_ready` & !(state==`MEM_WAIT` & `wcnt`==`MEM_TIMEOUT`).
- `load_use` = `ex_readMem`!=0 & `ex_writeReg` & `ex_rd`!=0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- Priority of hazard responses, highest first:
  1. `mem_stall`: `pc_hold`=`ifid_hold`=`idex_hold`=`exmem_hold`=1 and `memwb_flush`=1. All other outputs are 0. Redirect and load-use are ignored, because EX is frozen and they re-evaluate later.
  2. `ex_redirect`: `ifid_flush`=`idex_flush`=1. No hold. A load-use hazard in the same cycle is ignored because the ID instruction is wrong-path.
  3. `load_use`: `pc_hold`=`ifid_hold`=1 and `idex_flush`=1, giving a single bubble. In the next cycle `ex_readMem`=0, so the hazard does not re-assert.
- FSM transitions:
  - `RUN`→`MEM_WAIT` when `mem_stall`; set `wcnt`=1.
  - In `MEM_WAIT`:
    - `mem_ready`=1: go to `RUN`, `wcnt`=0, no stall that cycle.
    - `wcnt`==`MEM_TIMEOUT`: `mem_timeout`=1, go to `RUN`, `wcnt`=0, pipeline advances.
    - Otherwise: `wcnt`+1.
  - In `MEM_WAIT`, `mem_req`=0 returns to `RUN` without stall (access dropped).
- Performance counters:
  - `stall_cycles`+1 on each cycle with `pc_hold`.
  - `flush_count`+1 on each cycle in which `ex_redirect` is honored (not masked by `mem_stall`).
  - Both saturate at all-ones.

## Timing
- All hold, flush and `mem_timeout` outputs are combinational from the current state and inputs. They act at the same clock edge.
- The FSM, `wcnt` and the counters are registered.
- Reset: state=`RUN`, `wcnt`=0, counters=0. With all inputs at 0 after reset, every output is 0.
- `rst` asserted mid-stall returns the FSM to `RUN` on the next edge. Outputs in the reset cycle follow the combinational rules.
- Maximum memory stall is `MEM_TIMEOUT` cycles per access.
- Load-use penalty is exactly 1 cycle. Redirect penalty is exactly 2 squashed instructions.

## Structure
- Package `hazard_pkg` holds:
  - the state enum `hz_state_t` (`RUN`, `MEM_WAIT`);
  - the `REG_X0` constant;
  - the load-type encodings used to test `ex_readMem`.
- Submodule `sat_counter` (parameter `W`; ports `clk`, `rst`, `inc`, `q`) is instantiated twice for the performance counters.

## Test plan
- Load-use: EX has `ex_readMem`=3'b010, `ex_writeReg`=1, `ex_rd`=5. ID has `id_rs1`=5, `id_use_rs1`=1. Required: one cycle of `pc_hold`=`ifid_hold`=`idex_flush`=1, then all outputs 0; `stall_cycles`=1.
- x0 and unused source: same as above but with `ex_rd`=0, or with `id_use_rs1`=0. Required: no stall.
- Redirect plus load-use in the same cycle: `ex_redirect`=1. Required: only `ifid_flush`=`idex_flush`=1 and `flush_count`+1.
- Memory wait: `mem_req`=1, `mem_ready` low for 3 cycles then high. Required: 3 stall cycles with `memwb_flush`=1, release in the 4th cycle, `stall_cycles`=3.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready` never asserted. Required: stall for 4 cycles, `mem_timeout` pulses in the 5th cycle, FSM back in `RUN`.
- Reset mid-`MEM_WAIT` and saturation: `rst` pulse clears counters and FSM. With `CNT_W`=4 and 20 stall cycles, `stall_cycles` holds at 15.
